// File: rtl/dh_modexp_ctrl.sv
// Diffie-Hellman modular exponentiation controller: left-to-right square-and-multiply over
// all 32 exponent bits, with every mod-p step delegated to a shared external reducer.
module dh_modexp_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] base,
  input  logic [31:0] exp_key,
  input  logic [31:0] p,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result,
  output logic        red_st,
  output logic [63:0] red_op,
  output logic [31:0] red_p,
  input  logic        red_done,
  input  logic [31:0] red_r
);

  typedef enum logic [3:0] {
    IDLE, CHK, RB_REQ, RB_WAIT, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, NEXT, FIN
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] base_reg, exp_reg, p_reg;
  logic [31:0] acc_reg, gb_reg, result_reg;
  logic [4:0]  idx_reg;
  logic        err_reg;
  logic        p_small;
  logic [31:0] mul_b;
  logic [63:0] prod;

  assign p_small = (p_reg < 32'd2);

  // One multiplier serves both the square and the multiply-by-gb steps.
  assign mul_b = ((state_reg == MUL_REQ) || (state_reg == MUL_WAIT)) ? gb_reg : acc_reg;
  assign prod  = {32'd0, acc_reg} * {32'd0, mul_b};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:     if (start) state_next = CHK;
        CHK:      state_next = p_small ? FIN : RB_REQ;
        RB_REQ:   state_next = RB_WAIT;
        RB_WAIT:  if (red_done) state_next = SQ_REQ;
        SQ_REQ:   state_next = SQ_WAIT;
        SQ_WAIT:  if (red_done) state_next = exp_reg[idx_reg] ? MUL_REQ : NEXT;
        MUL_REQ:  state_next = MUL_WAIT;
        MUL_WAIT: if (red_done) state_next = NEXT;
        NEXT:     state_next = (idx_reg == 5'd0) ? FIN : SQ_REQ;
        FIN:      state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Operand is derived from registers that only change on leaving a wait state,
  // so it stays stable for the whole request.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    red_st = 1'b0;
    red_op = 64'd0;
    case (state_reg)
      CHK, NEXT: busy = 1'b1;
      RB_REQ, RB_WAIT: begin
        busy   = 1'b1;
        red_st = 1'b1;
        red_op = {32'd0, base_reg};
      end
      SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT: begin
        busy   = 1'b1;
        red_st = 1'b1;
        red_op = prod;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_reg   <= 32'd0;
      exp_reg    <= 32'd0;
      p_reg      <= 32'd0;
      acc_reg    <= 32'd0;
      gb_reg     <= 32'd0;
      result_reg <= 32'd0;
      idx_reg    <= 5'd0;
      err_reg    <= 1'b0;
    end else if (!abort) begin
      case (state_reg)
        IDLE: if (start) begin
          base_reg <= base;
          exp_reg  <= exp_key;
          p_reg    <= p;
          acc_reg  <= 32'd1;
          idx_reg  <= 5'd31;
          err_reg  <= 1'b0;
        end
        CHK: if (p_small) begin
          err_reg    <= 1'b1;
          result_reg <= 32'd0;
        end
        RB_WAIT:           if (red_done) gb_reg <= red_r;
        SQ_WAIT, MUL_WAIT: if (red_done) acc_reg <= red_r;
        // Result is loaded on the way into FIN so it is valid while done is high.
        NEXT: begin
          if (idx_reg == 5'd0) result_reg <= acc_reg;
          else                 idx_reg    <= idx_reg - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign err    = err_reg;
  assign result = result_reg;
  assign red_p  = p_reg;

endmodule

// File: tb/tb_dh_modexp_ctrl.sv
// Self-checking bench for dh_modexp_ctrl: latency-programmable reducer model plus a
// right-to-left modexp reference; directed cases followed by randomized operands.
module tb_dh_modexp_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] base = 32'd0;
  logic [31:0] exp_key = 32'd0;
  logic [31:0] p = 32'd0;
  logic        busy, done, err, red_st;
  logic [31:0] result, red_p;
  logic [63:0] red_op;
  logic        red_done = 1'b0;
  logic [31:0] red_r = 32'd0;

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          nreds = 0;
  int          cyc = 0;
  int          last_fire = 0;
  int          done_cnt = 0;
  bit          red_st_seen = 1'b0;
  logic [31:0] last_exp = 32'd0;

  dh_modexp_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base(base), .exp_key(exp_key), .p(p),
    .busy(busy), .done(done), .err(err), .result(result),
    .red_st(red_st), .red_op(red_op), .red_p(red_p),
    .red_done(red_done), .red_r(red_r)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_modexp(input logic [31:0] g, input logic [31:0] x,
                                             input logic [31:0] m);
    logic [63:0] r, b;
    if (m < 32'd2) return 32'd0;
    r = 64'd1;
    b = {32'd0, g % m};
    for (int k = 0; k < 32; k++) begin
      if (x[k]) r = (r * b) % {32'd0, m};
      b = (b * b) % {32'd0, m};
    end
    return r[31:0];
  endfunction

  // Reducer: answers lat cycles after a request appears, checks operand stability meanwhile.
  initial begin
    bit          pend;
    int          cnt;
    logic [63:0] op_snap;
    pend = 1'b0;
    cnt = 0;
    op_snap = 64'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (!rst) begin
        red_done = 1'b0;
        pend = 1'b0;
      end else begin
        if (red_done) begin
          red_done = 1'b0;
          pend = 1'b0;
        end
        if (red_st) begin
          red_st_seen = 1'b1;
          if (!pend) begin
            pend = 1'b1;
            cnt = lat;
            op_snap = red_op;
          end else begin
            check_eq("red_op_stable", red_op, op_snap);
            if (cnt == 1) begin
              red_done = 1'b1;
              red_r = (red_p != 32'd0) ? 32'(red_op % {32'd0, red_p}) : 32'd0;
              nreds++;
              last_fire = cyc;
            end else begin
              cnt--;
            end
          end
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] g, input logic [31:0] x, input logic [31:0] pp,
                        input int l, input int inject, input bit watch);
    logic [31:0] exp_r;
    int          exp_n, cycles, d0;
    exp_r = ref_modexp(g, x, pp);
    exp_n = (pp < 32'd2) ? 0 : 33 + $countones(x);
    lat = l;
    nreds = 0;
    red_st_seen = 1'b0;
    d0 = done_cnt;
    base = g; exp_key = x; p = pp;
    start = 1'b1;
    tick();
    start = 1'b0;
    base = $urandom; exp_key = $urandom; p = $urandom;
    cycles = 1;
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);
    while (!done && cycles < 6000) begin
      tick();
      cycles++;
      start = (cycles == inject);
    end
    start = 1'b0;
    check_eq("done_seen", {63'd0, done}, 64'd1);
    check_eq("result", {32'd0, result}, {32'd0, exp_r});
    check_eq("err", {63'd0, err}, {63'd0, pp < 32'd2});
    check_eq("reductions", 64'(nreds), 64'(exp_n));
    check_eq("red_p", {32'd0, red_p}, {32'd0, pp});
    check_eq("busy_at_done", {63'd0, busy}, 64'd0);
    if (pp < 32'd2) begin
      check_eq("err_latency", 64'(cycles), 64'd2);
      check_eq("red_st_quiet", {63'd0, red_st_seen}, 64'd0);
    end else begin
      check_eq("done_latency", 64'(cyc - last_fire), 64'd2);
    end
    tick();
    check_eq("done_pulse", {63'd0, done}, 64'd0);
    if (watch) begin
      repeat (200) tick();
      check_eq("single_done", 64'(done_cnt - d0), 64'd1);
      check_eq("result_held", {32'd0, result}, {32'd0, exp_r});
    end
    last_exp = exp_r;
    $display("op g=%0d x=%08h p=%0d lat=%0d result=%0d reds=%0d cycles=%0d",
             g, x, pp, l, result, nreds, cycles);
  endtask

  initial begin
    int d0, k;
    repeat (3) tick();
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_err", {63'd0, err}, 64'd0);
    check_eq("rst_red_st", {63'd0, red_st}, 64'd0);
    check_eq("rst_result", {32'd0, result}, 64'd0);
    check_eq("rst_red_op", red_op, 64'd0);
    rst = 1'b1;
    tick();

    run_op(32'd5, 32'd3, 32'd17, 1, 0, 1'b0);
    check_eq("vec_5_3_17", {32'd0, result}, 64'd6);
    run_op(32'd5, 32'd6, 32'd23, 1, 0, 1'b0);
    check_eq("vec_5_6_23", {32'd0, result}, 64'd8);
    run_op(32'd22, 32'd2, 32'd7, 1, 0, 1'b0);
    check_eq("vec_22_2_7", {32'd0, result}, 64'd1);
    run_op(32'd9, 32'd0, 32'd17, 1, 0, 1'b0);
    check_eq("vec_x0", {32'd0, result}, 64'd1);
    run_op(32'd9, 32'd5, 32'd1, 1, 0, 1'b0);
    run_op(32'd0, 32'd77, 32'd101, 2, 0, 1'b0);
    run_op(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd65521, 1, 0, 1'b0);
    run_op(32'd5, 32'd3, 32'd17, 6, 0, 1'b0);
    run_op(32'd1234567, 32'hDEAD_BEEF, 32'd1000003, 1, 20, 1'b1);

    for (int n = 0; n < 10; n++) begin
      logic [31:0] rp;
      rp = (n % 3 == 0) ? $urandom_range(100, 2) : $urandom;
      run_op($urandom, $urandom, rp, $urandom_range(3, 1), 0, 1'b0);
    end

    // Abort while the first square is in flight.
    lat = 4;
    nreds = 0;
    base = 32'd7; exp_key = 32'd0; p = 32'd101;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (nreds < 1 && k < 100) begin
      tick();
      k++;
    end
    check_eq("abort_rb_fired", 64'(nreds), 64'd1);
    tick();
    tick();
    check_eq("abort_in_wait", {63'd0, red_st}, 64'd1);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_busy", {63'd0, busy}, 64'd0);
    check_eq("abort_red_st", {63'd0, red_st}, 64'd0);
    check_eq("abort_result", {32'd0, result}, {32'd0, last_exp});
    repeat (20) tick();
    check_eq("abort_no_done", 64'(done_cnt - d0), 64'd0);
    $display("op abort base=7 p=101 result=%0d busy=%0d", result, busy);

    // Reset in the middle of a later run.
    lat = 1;
    base = 32'd3; exp_key = $urandom; p = 32'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    d0 = done_cnt;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_rst_done", {63'd0, done}, 64'd0);
    check_eq("mid_rst_err", {63'd0, err}, 64'd0);
    check_eq("mid_rst_red_st", {63'd0, red_st}, 64'd0);
    check_eq("mid_rst_result", {32'd0, result}, 64'd0);
    check_eq("mid_rst_red_op", red_op, 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (150) tick();
    check_eq("post_rst_idle", {63'd0, busy}, 64'd0);
    check_eq("post_rst_no_done", 64'(done_cnt - d0), 64'd0);
    $display("op reset mid-run busy=%0d result=%0d", busy, result);

    run_op($urandom, $urandom, 32'd4294967291, 2, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
